// File: rtl/multi_tap_mac_pkg.sv
// Shared default parameters and width helpers for the multi_tap_mac block.
package multi_tap_mac_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_COEFF_WIDTH = 8;
    localparam int DEF_NUM_TAPS    = 4;
    localparam int DEF_ACC_EXTRA   = 4;

    function automatic int prod_w(input int dw, input int cw);
        return dw + cw;
    endfunction

    // Sum of nt full-width products needs clog2(nt) extra bits to stay exact.
    function automatic int tree_w(input int dw, input int cw, input int nt);
        return prod_w(dw, cw) + $clog2(nt);
    endfunction

    function automatic int res_w(input int dw, input int cw, input int nt, input int ae);
        return tree_w(dw, cw, nt) + ae;
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Combinational unsigned binary adder tree over NUM_TAPS products (NUM_TAPS a power of two).
module mac_adder_tree
    import multi_tap_mac_pkg::*;
#(
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int PROD_W   = prod_w(DEF_DATA_WIDTH, DEF_COEFF_WIDTH),
    parameter int TREE_W   = tree_w(DEF_DATA_WIDTH, DEF_COEFF_WIDTH, DEF_NUM_TAPS)
) (
    input  logic [NUM_TAPS*PROD_W-1:0] prod_i,
    output logic [TREE_W-1:0]          sum_o
);

    // Heap layout: node k has children 2k+1 and 2k+2; leaves start at NUM_TAPS-1.
    logic [TREE_W-1:0] node [2*NUM_TAPS-1];

    for (genvar t = 0; t < NUM_TAPS; t++) begin : g_leaf
        assign node[NUM_TAPS-1+t] = TREE_W'(prod_i[t*PROD_W +: PROD_W]);
    end

    for (genvar k = 0; k < NUM_TAPS-1; k++) begin : g_node
        assign node[k] = node[2*k+1] + node[2*k+2];
    end

    assign sum_o = node[0];

endmodule

// File: rtl/multi_tap_mac.sv
// Three-stage multi-tap multiply-accumulate with frame accumulation and output backpressure.
// Define MULTI_TAP_MAC_SAT_EN to saturate the frame sum and report a sticky overflow flag.
module multi_tap_mac
    import multi_tap_mac_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int NUM_TAPS    = DEF_NUM_TAPS,
    parameter int ACC_EXTRA   = DEF_ACC_EXTRA
) (
    input  logic                                                           clk,
    input  logic                                                           reset,
    input  logic                                                           in_valid,
    output logic                                                           in_ready,
    input  logic [NUM_TAPS*DATA_WIDTH-1:0]                                 data,
    input  logic [NUM_TAPS*COEFF_WIDTH-1:0]                                coeff,
    input  logic                                                           acc_mode,
    input  logic                                                           in_last,
    output logic                                                           out_valid,
    input  logic                                                           out_ready,
    output logic [res_w(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS, ACC_EXTRA)-1:0] result,
    output logic                                                           out_overflow
);

    localparam int PROD_W = prod_w(DATA_WIDTH, COEFF_WIDTH);
    localparam int TREE_W = tree_w(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
    localparam int RES_W  = res_w(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS, ACC_EXTRA);

    logic                       advance;

    logic                       s1_valid_q, s1_valid_d;
    logic                       s1_close_q, s1_close_d;
    logic [NUM_TAPS*PROD_W-1:0] s1_prod_q, s1_prod_d;
    logic [NUM_TAPS*PROD_W-1:0] prod_now;

    logic                       s2_valid_q, s2_valid_d;
    logic                       s2_close_q, s2_close_d;
    logic [TREE_W-1:0]          s2_sum_q, s2_sum_d;
    logic [TREE_W-1:0]          tree_sum;

    logic [RES_W-1:0]           acc_q, acc_d;
    logic [RES_W-1:0]           result_q, result_d;
    logic                       out_valid_q, out_valid_d;
    logic [RES_W-1:0]           beat_total;

    // Every stage moves together; the only stall source is an unaccepted result.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance && !reset;

    always_comb begin
        prod_now = '0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            prod_now[t*PROD_W +: PROD_W] = PROD_W'(data[t*DATA_WIDTH +: DATA_WIDTH])
                                         * PROD_W'(coeff[t*COEFF_WIDTH +: COEFF_WIDTH]);
        end
    end

    mac_adder_tree #(
        .NUM_TAPS (NUM_TAPS),
        .PROD_W   (PROD_W),
        .TREE_W   (TREE_W)
    ) u_tree (
        .prod_i (s1_prod_q),
        .sum_o  (tree_sum)
    );

`ifdef MULTI_TAP_MAC_SAT_EN
    localparam int SUM_W = RES_W + 1;

    logic [SUM_W-1:0] sum_wide;
    logic             beat_ovf;
    logic             sticky_q, sticky_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        sum_wide   = {1'b0, acc_q} + SUM_W'(s2_sum_q);
        beat_ovf   = sum_wide[RES_W];
        beat_total = beat_ovf ? '1 : sum_wide[RES_W-1:0];
    end

    // Sticky flag collects any clamp within the frame and is handed to the output on close.
    always_comb begin
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
        if (advance && s2_valid_q) begin
            if (s2_close_q) begin
                ovf_d    = sticky_q | beat_ovf;
                sticky_d = 1'b0;
            end else begin
                sticky_d = sticky_q | beat_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_overflow = ovf_q;
`else
    always_comb begin
        beat_total = acc_q + RES_W'(s2_sum_q);
    end

    assign out_overflow = 1'b0;
`endif

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_close_d  = s1_close_q;
        s1_prod_d   = s1_prod_q;
        s2_valid_d  = s2_valid_q;
        s2_close_d  = s2_close_q;
        s2_sum_d    = s2_sum_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        if (advance) begin
            s1_valid_d  = in_valid;
            s1_close_d  = !acc_mode || in_last;
            s1_prod_d   = prod_now;

            s2_valid_d  = s1_valid_q;
            s2_close_d  = s1_close_q;
            s2_sum_d    = tree_sum;

            // Either the previous result was taken or there was none.
            out_valid_d = 1'b0;
            if (s2_valid_q) begin
                if (s2_close_q) begin
                    result_d    = beat_total;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d       = beat_total;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_close_q  <= 1'b0;
            s1_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_close_q  <= 1'b0;
            s2_sum_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_close_q  <= s1_close_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s2_valid_d;
            s2_close_q  <= s2_close_d;
            s2_sum_q    <= s2_sum_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: doc/multi_tap_mac.md
MULTI_TAP_MAC -- requirements
Module: multi_tap_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, unsigned sample width.
REQ-002 SHALL have parameter COEFF_WIDTH, default 8, unsigned coefficient width.
REQ-003 SHALL have parameter NUM_TAPS, default 4, number of parallel taps; legal values are the powers of two 2..16.
REQ-004 SHALL have parameter ACC_EXTRA, default 4, accumulator guard bits; RES_W = DATA_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS)+ACC_EXTRA.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  input beat present.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 data  input  NUM_TAPS*DATA_WIDTH  packed samples; tap i is at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 coeff  input  NUM_TAPS*COEFF_WIDTH  packed coefficients, same tap order as data.
REQ-012 acc_mode  input  1  1 = accumulate across beats; 0 = each beat stands alone.
REQ-013 in_last  input  1  closes an accumulation frame.
REQ-014 out_valid  output  1  result present.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 result  output  RES_W  frame sum.
REQ-017 out_overflow  output  1  frame overflowed; qualified by out_valid.

Function
REQ-018 A beat is accepted when in_valid && in_ready; beat sum = sum over i of data[i]*coeff[i], unsigned, computed without truncation.
REQ-019 A beat closes a frame if acc_mode==0 or in_last==1; otherwise it is non-closing.
REQ-020 Three-stage pipeline: S1 registers the NUM_TAPS products; S2 registers the tree sum and close flag; S3 updates the accumulator and the output.
REQ-021 Non-closing beat at S3: acc += beat sum; out_valid is not asserted.
REQ-022 Closing beat at S3: result = acc + beat sum; out_valid = 1; acc is cleared to 0 in the same cycle.
REQ-023 Latency: a closing beat accepted on cycle N SHALL produce out_valid on cycle N+3 when there is no stall.
REQ-024 Stall: advance = !out_valid || out_ready; in_ready = advance && !reset; all stages hold when advance==0.
REQ-025 While stalled, result and out_overflow SHALL hold stable; no beat is dropped or duplicated, and order is preserved.
REQ-026 Full throughput is one beat per cycle while out_ready==1.
REQ-027 Simultaneous output handshake and new input acceptance in the same cycle are legal.
REQ-028 acc_mode and in_last are sampled per beat and travel with their beat through the pipeline.

Reset
REQ-029 On reset: every pipeline valid = 0, acc = 0, result = 0, out_valid = 0, out_overflow = 0, in_ready = 0.
REQ-030 Reset mid-frame or mid-stall SHALL discard all partial sums and in-flight beats; the first closing beat after reset reports only post-reset beats.

Configuration
REQ-031 Macro MULTI_TAP_MAC_SAT_EN defined: if acc + beat sum exceeds 2^RES_W-1, the value SHALL clamp to 2^RES_W-1 and a sticky frame flag is set.
REQ-032 With MULTI_TAP_MAC_SAT_EN defined, the sticky flag SHALL be reported on out_overflow with the closing result and cleared with acc.
REQ-033 Macro MULTI_TAP_MAC_SAT_EN undefined: the sum SHALL wrap modulo 2^RES_W and out_overflow SHALL be tied to 0.

Structure
REQ-034 Package multi_tap_mac_pkg SHALL hold the default parameter constants and the RES_W / product-width / tree-width computation functions.
REQ-035 Sub-module mac_adder_tree SHALL perform the combinational NUM_TAPS-input unsigned tree sum feeding S2.

Verification
(NUM_TAPS=4, DATA_WIDTH=COEFF_WIDTH=8, ACC_EXTRA=4, RES_W=22)
REQ-036 acc_mode=0, data{15,10,0,0}, coeff{2,3,0,0} -> result 60 exactly 3 cycles after acceptance, out_overflow 0.
REQ-037 acc_mode=0, all data 255, all coeff 255 -> result 260100.
REQ-038 acc_mode=1, 3 beats data{1,2,3,4}, coeff{1,1,1,1}, in_last on the third beat -> one output of 30; no out_valid for beats 1-2.
REQ-039 Three back-to-back closing beats with out_ready low for 5 cycles -> in_ready low, result stable, all three results delivered in order after release.
REQ-040 acc_mode=1, 17 max beats -> with MULTI_TAP_MAC_SAT_EN: result 4194303, out_overflow 1; without: result 227396, out_overflow 0.
REQ-041 Two non-closing beats, then reset, then a closing beat of sum 10 -> result 10.
